// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port ram between M0 (fetch) and M1 (load/store).
// Ports: Clk/Rst_n (async active-low); M0_*/M1_* master Cs/We/Addr/Wdata in, Rdata/Ack out;
// Ram_* registered request out, Ram_Rdata/Ram_Ack response in; Gnt one-hot owner.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise M1 has fixed priority.
`ifndef RAM_CAPACITY
`define RAM_CAPACITY 4096
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 4
`endif
module ram_arbiter #(
  parameter int ADDR_W = $clog2(`RAM_CAPACITY),
  parameter int DATA_W = 8 * `WORD_SIZE
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              M0_Cs,
  input  logic              M0_We,
  input  logic [ADDR_W-1:0] M0_Addr,
  input  logic [DATA_W-1:0] M0_Wdata,
  output logic [DATA_W-1:0] M0_Rdata,
  output logic              M0_Ack,
  input  logic              M1_Cs,
  input  logic              M1_We,
  input  logic [ADDR_W-1:0] M1_Addr,
  input  logic [DATA_W-1:0] M1_Wdata,
  output logic [DATA_W-1:0] M1_Rdata,
  output logic              M1_Ack,
  output logic              Ram_Cs,
  output logic              Ram_We,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic [DATA_W-1:0] Ram_Wdata,
  input  logic [DATA_W-1:0] Ram_Rdata,
  input  logic              Ram_Ack,
  output logic [1:0]        Gnt
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic req, win1;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_m1;
`endif
  always_comb begin
    req = M0_Cs | M1_Cs;
`ifdef ARB_ROUND_ROBIN_EN
    // on a tie, the master that did not win last time takes the grant
    win1 = M1_Cs & (~M0_Cs | ~last_m1);
`else
    win1 = M1_Cs;
`endif
    state_nxt = state == IDLE ? (req ? BUSY : IDLE) : (Ram_Ack ? IDLE : BUSY);
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      Gnt       <= '0;
      Ram_We    <= 1'b0;
      Ram_Addr  <= '0;
      Ram_Wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        Gnt       <= win1 ? 2'b10 : 2'b01;
        Ram_We    <= win1 ? M1_We : M0_We;
        Ram_Addr  <= win1 ? M1_Addr : M0_Addr;
        Ram_Wdata <= win1 ? M1_Wdata : M0_Wdata;
      end else if (state == BUSY && Ram_Ack) begin
        Gnt    <= '0;
        Ram_We <= 1'b0;
      end
    end
  end
`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) last_m1 <= 1'b0;
    else if (state == IDLE && req) last_m1 <= win1;
  end
`endif
  assign Ram_Cs   = state == BUSY;
  assign M0_Ack   = Ram_Ack & Gnt[0];
  assign M1_Ack   = Ram_Ack & Gnt[1];
  assign M0_Rdata = (M0_Ack & ~Ram_We) ? Ram_Rdata : '0;
  assign M1_Rdata = (M1_Ack & ~Ram_We) ? Ram_Rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a transaction-level model.
module tb_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  logic Clk = 0, Rst_n = 1;
  logic m0_cs = 0, m0_we = 0, m1_cs = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = 0, m1_addr = 0;
  logic [DW-1:0] m0_wdata = 0, m1_wdata = 0;
  logic [DW-1:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic m0_ack, m1_ack, ram_cs, ram_we, ram_ack;
  logic [AW-1:0] ram_addr;
  logic [1:0] gnt;
  int pass_cnt = 0, total = 0, cyc = 0;
  bit chk_en = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .M0_Cs(m0_cs), .M0_We(m0_we), .M0_Addr(m0_addr), .M0_Wdata(m0_wdata),
    .M0_Rdata(m0_rdata), .M0_Ack(m0_ack),
    .M1_Cs(m1_cs), .M1_We(m1_we), .M1_Addr(m1_addr), .M1_Wdata(m1_wdata),
    .M1_Rdata(m1_rdata), .M1_Ack(m1_ack),
    .Ram_Cs(ram_cs), .Ram_We(ram_we), .Ram_Addr(ram_addr), .Ram_Wdata(ram_wdata),
    .Ram_Rdata(ram_rdata), .Ram_Ack(ram_ack), .Gnt(gnt)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // simple single-port ram: acks one cycle after seeing Cs
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ram_ack   <= 1'b0;
      ram_rdata <= '0;
    end else if (ram_cs && !ram_ack) begin
      ram_ack <= 1'b1;
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end else ram_ack <= 1'b0;
  end

  // transaction model: phase 0 idle, 1 request on ram, 2 ack cycle
  int phase = 0;
  int owner = 0;
  int last_owner = 0;
  bit we_l = 0;
  logic [AW-1:0] addr_l = 0;
  logic [DW-1:0] wd_l = 0;
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      phase = 0;
      last_owner = 0;
    end else if (phase == 0) begin
      if (m0_cs || m1_cs) begin
`ifdef ARB_ROUND_ROBIN_EN
        owner = (m0_cs && m1_cs) ? 1 - last_owner : (m1_cs ? 1 : 0);
`else
        owner = m1_cs ? 1 : 0;
`endif
        last_owner = owner;
        we_l   = owner == 1 ? m1_we : m0_we;
        addr_l = owner == 1 ? m1_addr : m0_addr;
        wd_l   = owner == 1 ? m1_wdata : m0_wdata;
        phase  = 1;
      end
    end else if (phase == 1) phase = 2;
    else begin
      if (we_l) shadow[addr_l] = wd_l;
      phase = 0;
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      logic a0, a1;
      a0 = phase == 2 && owner == 0;
      a1 = phase == 2 && owner == 1;
      check("ram_cs", ram_cs, phase != 0);
      check("gnt", gnt, phase == 0 ? 0 : (owner == 1 ? 2 : 1));
      check("ram_we", ram_we, phase != 0 && we_l);
      if (phase != 0) begin
        check("ram_addr", ram_addr, addr_l);
        if (we_l) check("ram_wdata", ram_wdata, wd_l);
      end
      check("m0_ack", m0_ack, a0);
      check("m1_ack", m1_ack, a1);
      check("m0_rdata", m0_rdata, (a0 && !we_l) ? shadow[addr_l] : 0);
      check("m1_rdata", m1_rdata, (a1 && !we_l) ? shadow[addr_l] : 0);
    end
  end

  bit seen0, seen1;
  always @(negedge Clk) begin
    seen0 <= m0_ack;
    seen1 <= m1_ack;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  int c1, c2, n;
  int order [4];
  int exp_order [4];
  bit prev_cs;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 0;
      shadow[i] = 0;
    end
    mem[12'h10] = 32'hDEADBEEF;
    shadow[12'h10] = 32'hDEADBEEF;
    #2 Rst_n = 0;
    tick;
    tick;
    #2 Rst_n = 1;
    chk_en = 1;
    tick;
    check("rst_ram_cs", ram_cs, 0);
    check("rst_gnt", gnt, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_m0_rdata", m0_rdata, 0);

    // single read
    m0_cs = 1; m0_we = 0; m0_addr = 12'h10;
    tick;
    check("rd_cs_n1", ram_cs, 1);
    check("rd_gnt_n1", gnt, 2'b01);
    tick;
    check("rd_ack_n2", m0_ack, 1);
    check("rd_data_n2", m0_rdata, 32'hDEADBEEF);
    check("rd_m1_ack", m1_ack, 0);
    m0_cs = 0;
    tick;
    check("rd_cs_n3", ram_cs, 0);

    // write by M1 then read by M0, both requested together
    m1_cs = 1; m1_we = 1; m1_addr = 12'h20; m1_wdata = 32'hCAFEF00D;
    m0_cs = 1; m0_we = 0; m0_addr = 12'h20;
    tick;
    c1 = cyc;
    check("wr_gnt", gnt, 2'b10);
    tick;
    check("wr_ack", m1_ack, 1);
    check("wr_rdata", m1_rdata, 0);
    m1_cs = 0; m1_we = 0;
    tick;
    check("gap_cs", ram_cs, 0);
    tick;
    c2 = cyc;
    check("rd2_gnt", gnt, 2'b01);
    check("cs_spacing", c2 - c1, 3);
    tick;
    check("rd2_ack", m0_ack, 1);
    check("rd2_data", m0_rdata, 32'hCAFEF00D);
    m0_cs = 0;
    tick;

    // both held for four grants
    m0_cs = 1; m1_cs = 1; m0_addr = 12'h10; m1_addr = 12'h20;
    n = 0;
    prev_cs = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (ram_cs && !prev_cs && n < 4) begin
        order[n] = gnt;
        n++;
      end
      prev_cs = ram_cs;
    end
    m0_cs = 0; m1_cs = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{2, 1, 2, 1};
`else
    exp_order = '{2, 2, 2, 2};
`endif
    check("grant_count", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("grant_%0d", i), order[i], exp_order[i]);
    tick;
    tick;

    // owner drops Cs while busy
    m0_cs = 1; m0_we = 0; m0_addr = 12'h10;
    tick;
    m0_cs = 0;
    #1;
    check("viol_cs", ram_cs, 1);
    tick;
    check("viol_ack", m0_ack, 1);
    check("viol_data", m0_rdata, 32'hDEADBEEF);
    tick;

    // reset mid-transaction
    m0_cs = 1; m0_we = 0; m0_addr = 12'h20;
    tick;
    check("mid_cs_before", ram_cs, 1);
    #2 Rst_n = 0;
    #1;
    check("mid_cs_async", ram_cs, 0);
    check("mid_gnt_async", gnt, 0);
    #2 Rst_n = 1;
    tick;
    check("mid_regrant", gnt, 2'b01);
    check("mid_no_ack", m0_ack, 0);
    tick;
    check("mid_ack", m0_ack, 1);
    check("mid_data", m0_rdata, 32'hCAFEF00D);
    m0_cs = 0;
    tick;

    // random traffic with reactive masters
    for (int i = 0; i < 3000; i++) begin
      if (m0_cs && seen0) m0_cs = 0;
      if (m1_cs && seen1) m1_cs = 0;
      if (!m0_cs && $urandom_range(0, 2) == 0) begin
        m0_cs = 1; m0_we = $urandom_range(0, 1);
        m0_addr = {$urandom_range(0, 15), 2'b00}; m0_wdata = $urandom;
      end
      if (!m1_cs && $urandom_range(0, 2) == 0) begin
        m1_cs = 1; m1_we = $urandom_range(0, 1);
        m1_addr = {$urandom_range(0, 15), 2'b00}; m1_wdata = $urandom;
      end
      tick;
    end
    m0_cs = 0; m1_cs = 0;
    tick;
    tick;
    tick;
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port `ram` between the instruction-fetch master (M0) and the load/store master (M1). It sits between the core and `ram`. It grants one request at a time, registers the granted request onto the RAM port, and routes the RAM's one-cycle `Ack` pulse and read data back to the owning master. Both master ports use the same Cs/We/Addr/Wdata/Rdata/Ack handshake as `ram`, so either master can also connect to `ram` directly.

## Interface
- `ADDR_W`, default `$clog2(`RAM_CAPACITY)`: byte address width.
- `DATA_W`, default `8*`WORD_SIZE``: data width.
- `Clk` in 1: single clock; all state changes on its rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `M0_Cs`, `M1_Cs` in 1: master request, held until that master's Ack.
- `M0_We`, `M1_We` in 1: write enable (1 = write, 0 = read).
- `M0_Addr`, `M1_Addr` in ADDR_W: byte address.
- `M0_Wdata`, `M1_Wdata` in DATA_W: write data.
- `M0_Rdata`, `M1_Rdata` out DATA_W: read data; valid only in that master's Ack cycle, 0 otherwise.
- `M0_Ack`, `M1_Ack` out 1: one-cycle completion pulse.
- `Ram_Cs`, `Ram_We` out 1: registered RAM request.
- `Ram_Addr` out ADDR_W, `Ram_Wdata` out DATA_W: registered RAM request.
- `Ram_Rdata` in DATA_W, `Ram_Ack` in 1: RAM response.
- `Gnt` out 2: one-hot current owner (bit 0 = M0, bit 1 = M1); 0 when idle.

## Operation
- FSM has two states.
  - IDLE: `Ram_Cs` = 0, `Gnt` = 0.
  - BUSY: `Ram_Cs` = 1, and `Gnt` names the owner.
- IDLE → BUSY: taken on any edge where at least one `Mx_Cs` is 1.
  - Winner chosen per Configuration.
  - Winner's We/Addr/Wdata are latched into `Ram_We`/`Ram_Addr`/`Ram_Wdata`; `Ram_Cs` ← 1; `Gnt` ← winner.
- BUSY: RAM outputs stay frozen; master inputs are ignored.
- Response routing is combinational:
  - `Mx_Ack = Ram_Ack & Gnt[x]`.
  - `Mx_Rdata = (Ram_Ack & Gnt[x] & ~Ram_We) ? Ram_Rdata : 0`.
- BUSY → IDLE: taken on the edge where `Ram_Ack` = 1. `Ram_Cs`, `Gnt` and `Ram_We` ← 0. `Ram_Addr`/`Ram_Wdata` may keep their values.
- Mandatory idle cycle: IDLE lasts at least one cycle after every transaction.
  - Keeps `Ram_Cs` low while the RAM drops its Ack.
  - Stale master Cs cannot be re-granted: a master deasserts Cs (or presents a new request) the cycle after its Ack.
- The losing master is not acknowledged. It keeps Cs high and is considered again at the next IDLE.
- If the owner drops Cs while BUSY (protocol violation), the latched transaction still completes and the Ack pulse is still issued.
- Asynchronous reset (`Rst_n` = 0), at any time including mid-transaction:
  - State → IDLE.
  - `Ram_Cs`, `Ram_We`, `Ram_Addr`, `Ram_Wdata`, `Gnt` → 0.
  - Round-robin pointer → M0 last (M1 favoured first).
  - Any in-flight transaction is dropped with no Ack.

## Timing
- Request sampled in IDLE at edge N → `Ram_Cs` high in cycle N+1.
- `ram` answers one cycle later: `Ram_Ack`, and therefore `Mx_Ack`, is high in cycle N+2.
- `Ram_Cs` is low in cycle N+3 (IDLE).
- Earliest next grant is at edge N+3, with `Ram_Cs` high in N+4.
- Per transaction: 2-cycle latency; 3-cycle throughput per access with back-to-back requests.
- All master outputs are 0 out of reset.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - On simultaneous requests, the master not granted last wins.
  - A single requester always wins.
  - The pointer updates on every grant.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, M1 always beats M0; no pointer register.

## Test plan
- Single read:
  - Setup: memory at 0x10 preloaded with 0xDEADBEEF.
  - Stimulus: M0 read 0x10.
  - Required: `M0_Ack` in cycle N+2 with `M0_Rdata` = 0xDEADBEEF; `M1_Ack` = 0 and `M1_Rdata` = 0 throughout.
- Write then read:
  - Stimulus: M1 writes 0xCAFEF00D to 0x20, then M0 reads 0x20.
  - Required: M1 Ack with `M1_Rdata` = 0; M0 then gets 0xCAFEF00D; 3 cycles between `Ram_Cs` rising edges.
- Simultaneous requests held for 4 transactions:
  - Round robin: grant order M1, M0, M1, M0.
  - Fixed priority: M1 held continuously → M1 on every grant, M0 starved.
- Reset mid-operation:
  - Stimulus: `Rst_n` pulsed low in cycle N+1 of an M0 read.
  - Required: `Ram_Cs`/`Gnt` drop to 0 immediately (asynchronous); no `M0_Ack`; the same request re-granted after reset release.
- Owner violation:
  - Stimulus: M0 drops Cs in cycle N+1.
  - Required: `Ram_Cs` stays 1 and `M0_Ack` still pulses in cycle N+2.
